// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the bus-interface variant of the MIPS core.
// Holds the memory arbiter state and grant encodings, the fixed fetch byte
// lane mask, the CPU reset vector, and a word-alignment helper.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUS_I,
    BUS_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } grant_t;

  localparam logic [3:0]  FETCH_BYTEENABLE = 4'b1111;
  localparam logic [31:0] RESET_VECTOR     = 32'hBFC0_0000;

  // Byte address -> bus word address (low two bits forced to zero).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Wait-cycle counter used as the bus watchdog.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; clears the count
//   clear    : synchronous clear (priority over enable)
//   enable   : count one cycle
//   expired  : high in the enabled cycle that brings the count to MAX_COUNT
module mips_wait_timer #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(MAX_COUNT - 1);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Expiry is flagged in the cycle that completes the MAX_COUNT-th wait,
  // so the owner can leave its bus state on that same edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Memory-port arbiter for the bus-interface MIPS core.
// Shares one Avalon-style master port between instruction fetch and data
// load/store, one transaction at a time, with alternating priority on
// contention, a CPU stall output and a sticky wait-cycle watchdog.
//   clk, reset                  : clock; synchronous active-high reset
//   i_req/i_addr                : fetch request (level) and byte address
//   i_rdata/i_valid             : fetched word and one-cycle completion pulse
//   d_read/d_write/d_addr       : data request (level, write wins) and address
//   d_wdata/d_byteenable        : store data and byte lanes
//   d_rdata/d_valid             : load data and one-cycle completion pulse
//   stall                       : CPU stall while a request is outstanding
//   avm_*                       : bus master port (word address)
//   timeout                     : sticky flag set when the watchdog fires
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        timeout
);

  arb_state_t state;
  arb_state_t state_next;
  grant_t     last_grant;

  logic d_req;
  logic start_i;
  logic start_d;
  logic in_bus;
  logic bus_done;
  logic wd_expired;

  assign d_req = d_read | d_write;

  mips_wait_timer #(
    .MAX_COUNT(MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_i | start_d),
    .enable (in_bus & avm_waitrequest),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_i    = 1'b0;
    start_d    = 1'b0;
    bus_done   = 1'b0;
    in_bus     = (state == BUS_I) || (state == BUS_D);
    unique case (state)
      IDLE: begin
        // On contention the port not granted last time goes first.
        if (i_req && (!d_req || last_grant == DATA)) begin
          start_i    = 1'b1;
          state_next = BUS_I;
        end else if (d_req) begin
          start_d    = 1'b1;
          state_next = BUS_D;
        end
      end
      BUS_I: begin
        if (!avm_waitrequest || wd_expired) begin
          bus_done   = 1'b1;
          state_next = RESP_I;
        end
      end
      BUS_D: begin
        if (!avm_waitrequest || wd_expired) begin
          bus_done   = 1'b1;
          state_next = RESP_D;
        end
      end
      RESP_I, RESP_D: state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Bus outputs are loaded once on BUS entry and held, so requester inputs
  // changing mid-transaction have no effect. A completing cycle that still
  // has waitrequest high can only be a watchdog abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= FETCH;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      i_rdata        <= '0;
      i_valid        <= 1'b0;
      d_rdata        <= '0;
      d_valid        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;

      if (start_i) begin
        last_grant     <= FETCH;
        avm_address    <= word_align(i_addr);
        avm_read       <= 1'b1;
        avm_write      <= 1'b0;
        avm_byteenable <= FETCH_BYTEENABLE;
      end else if (start_d) begin
        last_grant     <= DATA;
        avm_address    <= word_align(d_addr);
        avm_read       <= ~d_write;
        avm_write      <= d_write;
        avm_writedata  <= d_wdata;
        avm_byteenable <= d_byteenable;
      end

      if (bus_done) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
        if (avm_waitrequest) begin
          timeout <= 1'b1;
        end
        if (state == BUS_I) begin
          i_valid <= 1'b1;
          i_rdata <= avm_waitrequest ? TIMEOUT_DATA : avm_readdata;
        end else begin
          d_valid <= 1'b1;
          if (avm_read) begin
            d_rdata <= avm_waitrequest ? TIMEOUT_DATA : avm_readdata;
          end
        end
      end
    end
  end

  assign stall = (i_req & ~i_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed timing scenarios plus a
// randomized two-requester run against a bus slave model, with a scoreboard
// monitor that checks every completion pulse against queued expectations.
module tb_mips_mem_arbiter;

  localparam int CLK_HALF = 5;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        timeout;

  mips_mem_arbiter #(
    .MAX_WAIT(4),
    .TIMEOUT_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_valid        (i_valid),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_byteenable   (d_byteenable),
    .d_rdata        (d_rdata),
    .d_valid        (d_valid),
    .stall          (stall),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] exp_i[$];
  dexp_t       exp_d[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];

  int slave_mode  = 1;  // 0: random waits 0..3, 1: fixed waits, 2: stuck
  int fixed_waits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Power-on memory contents; the reset-vector word holds a known opcode.
  function automatic logic [31:0] init_word(input logic [31:0] wa);
    if (wa == 32'hBFC0_0000) return 32'h2402_000A;
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] wa);
    if (slave_mem.exists(wa)) return slave_mem[wa];
    return init_word(wa);
  endfunction

  // Reference: push the architecturally expected outcome of one data access.
  task automatic model_data(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] wa;
    dexp_t e;
    wa = addr & 32'hFFFF_FFFC;
    if (wr) begin
      ref_mem[wa] = merge(ref_rd(wa), wdata, be);
      e.wr = 1'b1;
      e.data = '0;
    end else begin
      e.wr = 1'b0;
      e.data = rd ? ref_rd(wa) : 32'h0;
    end
    exp_d.push_back(e);
  endtask

  // Bus slave: chooses a wait count per transaction, checks the master holds
  // its outputs steady, returns/stores data on the completing cycle.
  bit          s_busy = 0;
  int          s_left;
  logic [31:0] s_addr, s_wd;
  logic [3:0]  s_be;
  logic        s_rd, s_wr;

  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    forever begin
      @(negedge clk);
      if (!(avm_read || avm_write)) begin
        s_busy = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = $urandom;
      end else begin
        if (!s_busy) begin
          s_busy = 1;
          s_left = (slave_mode == 0) ? int'($urandom_range(0, 3)) :
                   (slave_mode == 1) ? fixed_waits : 1000;
          s_addr = avm_address; s_wd = avm_writedata; s_be = avm_byteenable;
          s_rd = avm_read; s_wr = avm_write;
          check("bus_addr_aligned", 32'(avm_address[1:0]), 32'h0);
          checkb("bus_single_strobe", avm_read & avm_write, 1'b0);
          if (avm_read && avm_address[31:24] == 8'hBF)
            check("fetch_byteenable", 32'(avm_byteenable), 32'hF);
        end else begin
          check("bus_addr_stable", avm_address, s_addr);
          check("bus_wdata_stable", avm_writedata, s_wd);
          check("bus_be_stable", 32'(avm_byteenable), 32'(s_be));
          checkb("bus_read_stable", avm_read, s_rd);
          checkb("bus_write_stable", avm_write, s_wr);
        end
        if (s_left > 0) begin
          s_left--;
          avm_waitrequest = 1'b1;
          avm_readdata = $urandom;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = s_rd ? slave_rd(s_addr) : $urandom;
          if (s_wr) slave_mem[s_addr] = merge(slave_rd(s_addr), s_wd, s_be);
        end
      end
    end
  end

  // Scoreboard monitor.
  logic [31:0] last_d_rdata = '0;
  initial begin
    logic [31:0] e;
    dexp_t de;
    forever begin
      @(negedge clk);
      if (reset) last_d_rdata = '0;
      if (i_valid) begin
        if (exp_i.size() == 0) fail_now("i_valid_unexpected");
        else begin
          e = exp_i.pop_front();
          check("i_rdata", i_rdata, e);
        end
      end
      if (d_valid) begin
        if (exp_d.size() == 0) fail_now("d_valid_unexpected");
        else begin
          de = exp_d.pop_front();
          if (de.wr) check("d_rdata_hold_on_write", d_rdata, last_d_rdata);
          else begin
            check("d_rdata", d_rdata, de.data);
            last_d_rdata = de.data;
          end
        end
      end
    end
  end

  // Issues one fetch and returns on the negedge its i_valid is seen, with
  // i_req still high. The address is scrambled while the bus access is live.
  task automatic fetch_txn(input logic [31:0] addr);
    bit got;
    got = 0;
    exp_i.push_back(ref_rd(addr & 32'hFFFF_FFFC));
    i_req = 1'b1;
    i_addr = addr;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (i_valid) got = 1;
      else if (avm_read && avm_address[31:24] == 8'hBF && $urandom_range(0, 1) == 1)
        i_addr = 32'hBFC0_0000 + 32'(4 * $urandom_range(0, 31));
    end
    if (!got) fail_now("fetch_valid_timeout");
  endtask

  task automatic data_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    bit got;
    got = 0;
    model_data(rd, wr, addr, wdata, be);
    d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (d_valid) got = 1;
      else if ((avm_read || avm_write) && avm_address[31:12] == 20'h00001 &&
               $urandom_range(0, 1) == 1) begin
        d_addr = 32'h1000 + 32'($urandom_range(0, 31));
        d_wdata = $urandom;
        d_byteenable = 4'($urandom_range(0, 15));
      end
    end
    if (!got) fail_now("data_valid_timeout");
  endtask

  initial begin
    #(CLK_HALF * 2 * 40000);
    fail_now("global_timeout");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    bit          seen_d[4];
    int          seen_k[4];
    int          nseen;
    logic [31:0] wd;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
    repeat (3) @(negedge clk);

    // Reset state
    checkb("rst_avm_read", avm_read, 1'b0);
    checkb("rst_avm_write", avm_write, 1'b0);
    checkb("rst_i_valid", i_valid, 1'b0);
    checkb("rst_d_valid", d_valid, 1'b0);
    checkb("rst_timeout", timeout, 1'b0);
    checkb("rst_stall", stall, 1'b0);
    check("rst_avm_address", avm_address, 32'h0);
    check("rst_avm_writedata", avm_writedata, 32'h0);
    check("rst_avm_byteenable", 32'(avm_byteenable), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only, zero wait
    slave_mode = 1; fixed_waits = 0;
    exp_i.push_back(32'h2402_000A);
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    #1 checkb("t1_stall_n", stall, 1'b1);
    @(negedge clk);
    checkb("t1_avm_read_n1", avm_read, 1'b1);
    check("t1_avm_address", avm_address, 32'hBFC0_0000);
    check("t1_byteenable", 32'(avm_byteenable), 32'hF);
    checkb("t1_stall_n1", stall, 1'b1);
    checkb("t1_i_valid_n1", i_valid, 1'b0);
    @(negedge clk);
    checkb("t1_i_valid_n2", i_valid, 1'b1);
    checkb("t1_stall_n2", stall, 1'b0);
    checkb("t1_avm_read_n2", avm_read, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    checkb("t1_i_valid_n3", i_valid, 1'b0);

    // Store with three wait cycles, inputs scrambled mid-flight
    fixed_waits = 3;
    wd = 32'hA5C3_7E19;
    model_data(1'b0, 1'b1, 32'h1003, wd, 4'b0010);
    d_write = 1'b1; d_addr = 32'h1003; d_wdata = wd; d_byteenable = 4'b0010;
    #1 checkb("t2_stall_n", stall, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkb("t2_avm_write", avm_write, 1'b1);
      checkb("t2_avm_read", avm_read, 1'b0);
      check("t2_avm_address", avm_address, 32'h1000);
      check("t2_avm_writedata", avm_writedata, wd);
      check("t2_byteenable", 32'(avm_byteenable), 32'h2);
      checkb("t2_d_valid_early", d_valid, 1'b0);
      checkb("t2_stall_wait", stall, 1'b1);
      if (k == 2) begin
        d_addr = 32'h1014; d_wdata = 32'h0; d_byteenable = 4'b1111;
      end
    end
    @(negedge clk);
    checkb("t2_d_valid", d_valid, 1'b1);
    checkb("t2_avm_write_drop", avm_write, 1'b0);
    checkb("t2_timeout_clear", timeout, 1'b0);
    d_write = 1'b0;
    @(negedge clk);

    // Read and write together: write wins
    fixed_waits = 0;
    model_data(1'b1, 1'b1, 32'h1008, 32'h1357_9BDF, 4'b1001);
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h1008; d_wdata = 32'h1357_9BDF;
    d_byteenable = 4'b1001;
    @(negedge clk);
    checkb("t6_avm_write", avm_write, 1'b1);
    checkb("t6_avm_read", avm_read, 1'b0);
    check("t6_avm_address", avm_address, 32'h1008);
    @(negedge clk);
    checkb("t6_d_valid", d_valid, 1'b1);
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);

    // Watchdog: slave never releases waitrequest
    slave_mode = 2;
    exp_d.push_back('{wr: 1'b0, data: 32'hFFFF_FFFF});
    d_read = 1'b1; d_addr = 32'h1010; d_byteenable = 4'b1111;
    checkb("t4_timeout_before", timeout, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkb("t4_avm_read_held", avm_read, 1'b1);
      checkb("t4_d_valid_early", d_valid, 1'b0);
    end
    @(negedge clk);
    checkb("t4_avm_read_drop", avm_read, 1'b0);
    checkb("t4_d_valid", d_valid, 1'b1);
    checkb("t4_timeout_set", timeout, 1'b1);
    d_read = 1'b0;
    slave_mode = 1; fixed_waits = 0;
    @(negedge clk);
    data_txn(1'b1, 1'b0, 32'h1014, 32'h0, 4'b1111);
    d_read = 1'b0;
    checkb("t4_timeout_sticky", timeout, 1'b1);
    @(negedge clk);

    // Reset during a stalled fetch
    slave_mode = 2;
    i_req = 1'b1; i_addr = 32'hBFC0_0010;
    @(negedge clk);
    checkb("t5_avm_read_bus", avm_read, 1'b1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    checkb("t5_avm_read_after", avm_read, 1'b0);
    checkb("t5_i_valid_after", i_valid, 1'b0);
    checkb("t5_timeout_cleared", timeout, 1'b0);
    checkb("t5_stall_after", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkb("t5_idle_no_read", avm_read, 1'b0);
      checkb("t5_idle_no_valid", i_valid, 1'b0);
    end

    // Contention from reset release: D, I, D, I every 3 cycles
    slave_mode = 1; fixed_waits = 0;
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'hBFC0_0008;
    d_read = 1'b1; d_write = 1'b0; d_addr = 32'h1004; d_byteenable = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      exp_d.push_back('{wr: 1'b0, data: ref_rd(32'h1004)});
      exp_i.push_back(ref_rd(32'hBFC0_0008));
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nseen = 0;
    for (int k = 1; k <= 30 && nseen < 4; k++) begin
      @(negedge clk);
      if (d_valid || i_valid) begin
        seen_d[nseen] = d_valid;
        seen_k[nseen] = k;
        nseen++;
        if (nseen == 4) begin
          i_req = 1'b0; d_read = 1'b0;
        end
      end
    end
    check("t3_completions", nseen, 4);
    for (int i = 0; i < nseen; i++) begin
      checkb("t3_grant_order", seen_d[i], (i % 2) == 0);
      check("t3_valid_cycle", seen_k[i], 2 + 3 * i);
    end
    repeat (3) @(negedge clk);

    // Randomized concurrent traffic
    slave_mode = 0;
    fork
      begin
        for (int t = 0; t < 120; t++) begin
          fetch_txn(32'hBFC0_0000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3)));
          if ($urandom_range(0, 2) == 0) begin
            i_req = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        i_req = 1'b0;
      end
      begin
        for (int t = 0; t < 120; t++) begin
          int op;
          op = int'($urandom_range(0, 3));
          data_txn(op != 2, op >= 2, 32'h1000 + 32'($urandom_range(0, 31)), $urandom,
                   4'($urandom_range(0, 15)));
          if ($urandom_range(0, 2) == 0) begin
            d_read = 1'b0; d_write = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        d_read = 1'b0; d_write = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    check("fetch_queue_drained", exp_i.size(), 0);
    check("data_queue_drained", exp_d.size(), 0);
    checkb("final_timeout_clear", timeout, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
